// File: rtl/ddr3_cmd_sequencer.sv
// DDR3 command sequencer: power-up init, closed-page read/write sequencing and
// periodic auto-refresh. Every DDR3 pin and datapath strobe leaves a flop.
module ddr3_cmd_sequencer #(
  parameter int BANK_WIDTH  = 3,
  parameter int ROW_WIDTH   = 13,
  parameter int COL_WIDTH   = 10,
  parameter int INIT_CYCLES = 500,
  parameter int tRCD        = 6,
  parameter int tRAS        = 15,
  parameter int tRW2PRE     = 8,
  parameter int tRP         = 6,
  parameter int tRFC        = 44,
  parameter int tREFI       = 3120
) (
  input  logic                                     CLK,
  input  logic                                     RST,
  input  logic                                     REQ_VALID,
  output logic                                     REQ_READY,
  input  logic                                     REQ_WRITE,
  input  logic [ROW_WIDTH+BANK_WIDTH+COL_WIDTH-1:0] REQ_ADDR,
  output logic                                     CKE,
  output logic                                     CS_N,
  output logic                                     RAS_N,
  output logic                                     CAS_N,
  output logic                                     WE_N,
  output logic [BANK_WIDTH-1:0]                    BA,
  output logic [ROW_WIDTH-1:0]                     ADDR,
  output logic                                     CMD_RD,
  output logic                                     CMD_WR,
  output logic                                     INIT_DONE
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int CNT_MAX = max2(max2(max2(INIT_CYCLES, tRCD), max2(tRAS, tRW2PRE)),
                                max2(tRP, tRFC));
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int REFI_W  = $clog2(tREFI + 1);

  localparam logic [CNT_W-1:0]  CNT_SAT   = CNT_W'(CNT_MAX);
  localparam logic [REFI_W-1:0] REFI_LAST = REFI_W'(tREFI - 1);

  // {CS_N, RAS_N, CAS_N, WE_N}
  typedef enum logic [3:0] {
    C_NOP   = 4'b0111,
    C_ACT   = 4'b0011,
    C_READ  = 4'b0101,
    C_WRITE = 4'b0100,
    C_PRE   = 4'b0010,
    C_REF   = 4'b0001
  } cmd_e;

  typedef enum logic [3:0] {
    S_INIT_WAIT, S_INIT_PRE, S_INIT_REF, S_IDLE,
    S_ACT, S_WAIT_RCD, S_RW, S_WAIT_PRE,
    S_PRE, S_WAIT_RP, S_REF, S_WAIT_RFC
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;          // cycles since the last command
  logic [CNT_W-1:0]      act_cnt_q, act_cnt_d;  // cycles since ACT
  logic [REFI_W-1:0]     refi_q, refi_d;
  logic                  ref_pend_q, ref_pend_d;
  logic                  cke_q, cke_d;
  logic                  init_done_q, init_done_d;
  cmd_e                  cmd_q, cmd_d;
  logic [BANK_WIDTH-1:0] ba_q, ba_d;
  logic [ROW_WIDTH-1:0]  addr_q, addr_d;
  logic                  rd_q, rd_d;
  logic                  wr_q, wr_d;
  logic [ROW_WIDTH-1:0]  row_q, row_d;
  logic [BANK_WIDTH-1:0] bank_q, bank_d;
  logic [COL_WIDTH-1:0]  col_q, col_d;
  logic                  write_q, write_d;
  logic                  ref_issue;

  // True when a command issued on the next cycle would be n cycles after the
  // one that reset counter c; n = 1 therefore fires straight away.
  function automatic logic due(input logic [CNT_W-1:0] c, input int n);
    return (int'(c) + 1) >= n;
  endfunction

  assign REQ_READY = (state_q == S_IDLE) && init_done_q && !ref_pend_q;

  // NOTE: every signal driven here gets a default before the case statement,
  // otherwise a path that skips an assignment infers a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;
    act_cnt_d   = (act_cnt_q == CNT_SAT) ? act_cnt_q : act_cnt_q + 1'b1;
    refi_d      = refi_q;
    cke_d       = cke_q;
    init_done_d = init_done_q;
    cmd_d       = C_NOP;
    ba_d        = '0;
    addr_d      = '0;
    rd_d        = 1'b0;
    wr_d        = 1'b0;
    row_d       = row_q;
    bank_d      = bank_q;
    col_d       = col_q;
    write_d     = write_q;
    ref_issue   = 1'b0;

    case (state_q)
      S_INIT_WAIT: if (due(cnt_q, INIT_CYCLES)) begin
        state_d     = S_INIT_PRE;
        cke_d       = 1'b1;
        cmd_d       = C_PRE;
        addr_d[10]  = 1'b1;
        cnt_d       = '0;
      end
      S_INIT_PRE: if (due(cnt_q, tRP)) begin
        state_d = S_INIT_REF;
        cmd_d   = C_REF;
        cnt_d   = '0;
      end
      S_INIT_REF: if (due(cnt_q, tRFC)) begin
        state_d     = S_IDLE;
        init_done_d = 1'b1;
      end
      S_IDLE: begin
        // Pending refresh wins over a request presented in the same cycle.
        if (ref_pend_q) begin
          state_d   = S_REF;
          cmd_d     = C_REF;
          cnt_d     = '0;
          ref_issue = 1'b1;
        end else if (REQ_VALID && REQ_READY) begin
          row_d     = REQ_ADDR[ROW_WIDTH+BANK_WIDTH+COL_WIDTH-1 -: ROW_WIDTH];
          bank_d    = REQ_ADDR[BANK_WIDTH+COL_WIDTH-1 -: BANK_WIDTH];
          col_d     = REQ_ADDR[COL_WIDTH-1:0];
          write_d   = REQ_WRITE;
          state_d   = S_ACT;
          cmd_d     = C_ACT;
          ba_d      = REQ_ADDR[BANK_WIDTH+COL_WIDTH-1 -: BANK_WIDTH];
          addr_d    = REQ_ADDR[ROW_WIDTH+BANK_WIDTH+COL_WIDTH-1 -: ROW_WIDTH];
          cnt_d     = '0;
          act_cnt_d = '0;
        end
      end
      S_ACT, S_WAIT_RCD: begin
        if (due(cnt_q, tRCD)) begin
          state_d                 = S_RW;
          cmd_d                   = write_q ? C_WRITE : C_READ;
          rd_d                    = !write_q;
          wr_d                    = write_q;
          ba_d                    = bank_q;
          addr_d[COL_WIDTH-1:0]   = col_q;
          addr_d[10]              = 1'b0;
          cnt_d                   = '0;
        end else begin
          state_d = S_WAIT_RCD;
        end
      end
      S_RW, S_WAIT_PRE: begin
        if (due(act_cnt_q, tRAS) && due(cnt_q, tRW2PRE)) begin
          state_d = S_PRE;
          cmd_d   = C_PRE;
          ba_d    = bank_q;
          cnt_d   = '0;
        end else begin
          state_d = S_WAIT_PRE;
        end
      end
      S_PRE, S_WAIT_RP:  state_d = due(cnt_q, tRP)  ? S_IDLE : S_WAIT_RP;
      S_REF, S_WAIT_RFC: state_d = due(cnt_q, tRFC) ? S_IDLE : S_WAIT_RFC;
      default:           state_d = S_INIT_WAIT;
    endcase

    // A fresh expiry always leaves pending set, so a coincident REF cannot
    // swallow the next interval and repeated expiries collapse into one REF.
    ref_pend_d = ref_pend_q && !ref_issue;
    if (init_done_q) begin
      if (refi_q == REFI_LAST) begin
        refi_d     = '0;
        ref_pend_d = 1'b1;
      end else begin
        refi_d = refi_q + 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= S_INIT_WAIT;
      cnt_q       <= '0;
      act_cnt_q   <= '0;
      refi_q      <= '0;
      ref_pend_q  <= 1'b0;
      cke_q       <= 1'b0;
      init_done_q <= 1'b0;
      cmd_q       <= C_NOP;
      ba_q        <= '0;
      addr_q      <= '0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      row_q       <= '0;
      bank_q      <= '0;
      col_q       <= '0;
      write_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      act_cnt_q   <= act_cnt_d;
      refi_q      <= refi_d;
      ref_pend_q  <= ref_pend_d;
      cke_q       <= cke_d;
      init_done_q <= init_done_d;
      cmd_q       <= cmd_d;
      ba_q        <= ba_d;
      addr_q      <= addr_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      row_q       <= row_d;
      bank_q      <= bank_d;
      col_q       <= col_d;
      write_q     <= write_d;
    end
  end

  assign CKE                       = cke_q;
  assign {CS_N, RAS_N, CAS_N, WE_N} = cmd_q;
  assign BA                        = ba_q;
  assign ADDR                      = addr_q;
  assign CMD_RD                    = rd_q;
  assign CMD_WR                    = wr_q;
  assign INIT_DONE                 = init_done_q;

endmodule
